wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone master arbiter that shares the single SoC intercon slave port between NUM_MASTERS masters.
- Port 0 is the picorv32 master; the other ports are for future DMA or debug masters.
- Includes a bus watchdog that terminates hung cycles with err, so a dead slave cannot lock the CPU.
- Sits between the masters and the wb_intercon master input.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_rr_arbiter_rr_pick.sv | 29 ++
 rtl/wb_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds FSM encodings, cycle-type/burst-type codes and a clog2 helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TOUT  = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first
// requester found searching upward from ptr with wrap-around.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // scan offsets 0..N-1 from ptr; the first active request wins
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[k] &&
            (k == (int'(ptr) + i) % N)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone master arbiter with a bus watchdog that
// terminates hung cycles with err so a dead slave cannot lock a master.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [AW*NUM_MASTERS-1:0]   m_adr_i,
  input  logic [DW*NUM_MASTERS-1:0]   m_dat_i,
  input  logic [DW/8*NUM_MASTERS-1:0] m_sel_i,
  input  logic [3*NUM_MASTERS-1:0]    m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int N  = NUM_MASTERS;
  localparam int SW = DW / 8;
  localparam int PW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int CW = (clog2(TIMEOUT + 1) > 0) ?
                      clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

  arb_state_t    state;
  logic [N-1:0]  grant;
  logic [N-1:0]  pick;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_nxt;
  logic [CW-1:0] wd_cnt;
  logic          g_cyc;
  logic          g_stb;
  logic          busy;
  logic          resp;
  logic          wd_inc;
  logic          wd_fire;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick)
  );

  // route the granted master's request onto the slave side
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    gidx    = '0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        g_cyc   = m_cyc_i[k];
        g_stb   = m_stb_i[k];
        gidx    = PW'(k);
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_cti_o = m_cti_i[k*3 +: 3];
        s_bte_o = m_bte_i[k*2 +: 2];
      end
    end
  end

  assign busy      = (state == ST_GRANT);
  assign s_cyc_o   = busy & g_cyc;
  assign s_stb_o   = busy & g_stb;
  assign resp      = s_ack_i | s_err_i | s_rty_i;
  assign wd_inc    = s_stb_o & ~resp;
  assign wd_fire   = (TIMEOUT != 0) && wd_inc &&
                     (wd_cnt == CNT_FIRE);
  assign ptr_nxt   = (gidx == IDX_LAST) ? '0 :
                     gidx + PW'(1);

  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant;
  assign timeout_o = (state == ST_TOUT);
  assign m_ack_o   = busy ? (grant & {N{s_ack_i}}) : '0;
  assign m_rty_o   = busy ? (grant & {N{s_rty_i}}) : '0;
  assign m_err_o   = (state == ST_TOUT) ? grant :
                     busy ? (grant & {N{s_err_i}}) : '0;

  // arbitration FSM, round-robin pointer and watchdog counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      grant  <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc_i) begin
            grant <= pick;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!g_cyc) begin
            ptr    <= ptr_nxt;
            grant  <= '0;
            state  <= ST_IDLE;
            wd_cnt <= '0;
          end else if (wd_fire) begin
            state  <= ST_TOUT;
            wd_cnt <= '0;
          end else if (wd_inc) begin
            if (wd_cnt != CNT_MAX)
              wd_cnt <= wd_cnt + CW'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        ST_TOUT: begin
          wd_cnt <= '0;
          if (!g_cyc) begin
            ptr   <= ptr_nxt;
            grant <= '0;
            state <= ST_IDLE;
          end else begin
            state <= ST_GRANT;
          end
        end
        default: begin
          state  <= ST_IDLE;
          grant  <= '0;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized scoreboard bench for wb_rr_arbiter: one instance with a
// short watchdog and one with the watchdog disabled, same stimulus.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    cyc, stb, we;
  logic [AW*N-1:0] adr;
  logic [DW*N-1:0] dat;
  logic [SW*N-1:0] sel;
  logic [3*N-1:0]  cti;
  logic [2*N-1:0]  bte;
  logic [DW-1:0]   sdat;
  logic            sack, serr, srty;

  logic [DW-1:0] a_mdat, b_mdat;
  logic [N-1:0]  a_ack, a_err, a_rty, a_gnt;
  logic [N-1:0]  b_ack, b_err, b_rty, b_gnt;
  logic          a_cyc, a_stb, a_we, a_tout;
  logic          b_cyc, b_stb, b_we, b_tout;
  logic [AW-1:0] a_adr, b_adr;
  logic [DW-1:0] a_dat, b_dat;
  logic [SW-1:0] a_sel, b_sel;
  logic [2:0]    a_cti, b_cti;
  logic [1:0]    a_bte, b_bte;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .TIMEOUT(8), .AW(AW), .DW(DW)
  ) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
    .m_cti_i(cti), .m_bte_i(bte),
    .m_dat_o(a_mdat), .m_ack_o(a_ack),
    .m_err_o(a_err), .m_rty_o(a_rty),
    .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_we_o(a_we),
    .s_adr_o(a_adr), .s_dat_o(a_dat), .s_sel_o(a_sel),
    .s_cti_o(a_cti), .s_bte_o(a_bte),
    .s_dat_i(sdat), .s_ack_i(sack),
    .s_err_i(serr), .s_rty_i(srty),
    .grant_o(a_gnt), .timeout_o(a_tout)
  );

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .TIMEOUT(0), .AW(AW), .DW(DW)
  ) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
    .m_cti_i(cti), .m_bte_i(bte),
    .m_dat_o(b_mdat), .m_ack_o(b_ack),
    .m_err_o(b_err), .m_rty_o(b_rty),
    .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_we_o(b_we),
    .s_adr_o(b_adr), .s_dat_o(b_dat), .s_sel_o(b_sel),
    .s_cti_o(b_cti), .s_bte_o(b_bte),
    .s_dat_i(sdat), .s_ack_i(sack),
    .s_err_i(serr), .s_rty_i(srty),
    .grant_o(b_gnt), .timeout_o(b_tout)
  );

  typedef struct {
    logic [N-1:0]  gnt, ack, err, rty;
    logic          cyc, stb, we, tout;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat, rdat;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t last_a;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int popped = 0;
  int n_tout = 0;
  bit done = 1'b0;

  // reference model: who owns the bus, whose turn is next,
  // how long the current strobe has been stalled
  int owner[2];
  int ptr[2];
  int stall[2];
  bit tout[2];
  int tmo[2] = '{8, 0};

  // master agents
  bit            act[N];
  bit            burst[N];
  int            beats[N];
  int            idle[N];
  logic [AW-1:0] madr[N];
  int            hang = 0;

  task automatic cmp(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, got, want, $time);
    end
  endtask

  task automatic model_step(input int i);
    int o;
    o = owner[i];
    if (rst) begin
      owner[i] = -1;
      ptr[i]   = 0;
      stall[i] = 0;
      tout[i]  = 1'b0;
    end else if (o < 0) begin
      stall[i] = 0;
      for (int d = 0; d < N; d++)
        if (owner[i] < 0 && cyc[(ptr[i] + d) % N])
          owner[i] = (ptr[i] + d) % N;
    end else if (!cyc[o]) begin
      ptr[i]   = (o + 1) % N;
      owner[i] = -1;
      stall[i] = 0;
      tout[i]  = 1'b0;
    end else if (tout[i]) begin
      tout[i]  = 1'b0;
      stall[i] = 0;
    end else if (stb[o] && !(sack || serr || srty)) begin
      stall[i]++;
      if (tmo[i] != 0 && stall[i] == tmo[i]) begin
        tout[i]  = 1'b1;
        stall[i] = 0;
      end
    end else begin
      stall[i] = 0;
    end
  endtask

  function automatic exp_t predict(input int i);
    exp_t e;
    int o;
    o = owner[i];
    e.gnt = '0; e.ack = '0; e.err = '0; e.rty = '0;
    e.cyc = 1'b0; e.stb = 1'b0; e.we = 1'b0;
    e.tout = tout[i];
    e.adr = '0; e.wdat = '0; e.sel = '0;
    e.cti = '0; e.bte = '0;
    e.rdat = sdat;
    if (o >= 0) begin
      e.gnt[o] = 1'b1;
      e.cyc  = !tout[i] && cyc[o];
      e.stb  = !tout[i] && stb[o];
      e.we   = we[o];
      e.adr  = adr[o*AW +: AW];
      e.wdat = dat[o*DW +: DW];
      e.sel  = sel[o*SW +: SW];
      e.cti  = cti[o*3 +: 3];
      e.bte  = bte[o*2 +: 2];
      e.ack[o] = !tout[i] && sack;
      e.rty[o] = !tout[i] && srty;
      e.err[o] = tout[i] || serr;
    end
    return e;
  endfunction

  task automatic master_step();
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        act[k]  = 1'b0;
        idle[k] = $urandom % 3;
      end else if (act[k]) begin
        if (last_a.err[k] || last_a.rty[k]) begin
          act[k]  = 1'b0;
          idle[k] = $urandom % 3;
        end else if (last_a.ack[k]) begin
          beats[k]--;
          madr[k] = madr[k] + 32'd4;
          if (beats[k] == 0) begin
            act[k]  = 1'b0;
            idle[k] = $urandom % 3;
          end
        end
      end else if (idle[k] > 0) begin
        idle[k]--;
      end else begin
        act[k]   = 1'b1;
        beats[k] = 1 + ($urandom % 4);
        burst[k] = (beats[k] > 1);
        madr[k]  = $urandom & 32'hffff_fffc;
      end
      cyc[k] = act[k];
      stb[k] = act[k] && ($urandom % 8 != 0);
      we[k]  = $urandom % 2;
      adr[k*AW +: AW] = madr[k];
      dat[k*DW +: DW] = $urandom;
      sel[k*SW +: SW] = SW'($urandom);
      if (!burst[k])
        cti[k*3 +: 3] = CTI_CLASSIC;
      else if (beats[k] == 1)
        cti[k*3 +: 3] = CTI_EOB;
      else
        cti[k*3 +: 3] = CTI_INCR;
      bte[k*2 +: 2] = ($urandom % 2) ? BTE_WRAP4 : BTE_LINEAR;
    end
  endtask

  task automatic slave_step(input exp_t e);
    int r;
    sack = 1'b0; serr = 1'b0; srty = 1'b0;
    sdat = $urandom;
    if (hang > 0) begin
      hang--;
    end else if ($urandom % 50 == 0) begin
      hang = 20;
    end else if (e.stb) begin
      r = $urandom % 20;
      sack = (r < 11);
      serr = (r == 11);
      srty = (r == 12);
    end else if (e.tout) begin
      sack = $urandom % 2;
    end
  endtask

  // stimulus: advance the model, drive new inputs, queue expectations
  initial begin
    exp_t ea, eb;
    cyc = '0; stb = '0; we = '0;
    adr = '0; dat = '0; sel = '0; cti = '0; bte = '0;
    sdat = '0; sack = 1'b0; serr = 1'b0; srty = 1'b0;
    for (int k = 0; k < N; k++) begin
      act[k] = 1'b0; burst[k] = 1'b0;
      beats[k] = 0; idle[k] = 0; madr[k] = '0;
    end
    last_a = predict(0);
    repeat (3) @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      master_step();
      rst = (c > 5) && ($urandom % 300 == 0);
      sack = 1'b0; serr = 1'b0; srty = 1'b0;
      slave_step(predict(0));
      ea = predict(0);
      eb = predict(1);
      if (ea.tout) n_tout++;
      qa.push_back(ea);
      qb.push_back(eb);
      pushed++;
      last_a = ea;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    cmp("scoreboard_drain", popped, pushed);
    cmp("watchdog_exercised", n_tout != 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic check(input string p, input exp_t e,
                       input logic [N-1:0] gnt, ack, err, rty,
                       input logic scyc, sstb, swe, tmo_o,
                       input logic [AW-1:0] sadr,
                       input logic [DW-1:0] swd, mrd,
                       input logic [SW-1:0] ssel,
                       input logic [2:0] scti,
                       input logic [1:0] sbte);
    cmp({p, "grant"}, gnt, e.gnt);
    cmp({p, "s_cyc"}, scyc, e.cyc);
    cmp({p, "s_stb"}, sstb, e.stb);
    cmp({p, "m_ack"}, ack, e.ack);
    cmp({p, "m_err"}, err, e.err);
    cmp({p, "m_rty"}, rty, e.rty);
    cmp({p, "timeout"}, tmo_o, e.tout);
    cmp({p, "m_dat"}, mrd, e.rdat);
    if (e.stb) begin
      cmp({p, "s_adr"}, sadr, e.adr);
      cmp({p, "s_we"}, swe, e.we);
      cmp({p, "s_dat"}, swd, e.wdat);
      cmp({p, "s_sel"}, ssel, e.sel);
      cmp({p, "s_cti"}, scti, e.cti);
      cmp({p, "s_bte"}, sbte, e.bte);
    end
  endtask

  // monitor: pop one expectation per instance each cycle and compare
  always @(negedge clk) begin
    exp_t e;
    if (!done && qa.size() != 0 && qb.size() != 0) begin
      e = qa.pop_front();
      check("a_", e, a_gnt, a_ack, a_err, a_rty,
            a_cyc, a_stb, a_we, a_tout, a_adr,
            a_dat, a_mdat, a_sel, a_cti, a_bte);
      e = qb.pop_front();
      check("b_", e, b_gnt, b_ack, b_err, b_rty,
            b_cyc, b_stb, b_we, b_tout, b_adr,
            b_dat, b_mdat, b_sel, b_cti, b_bte);
      popped++;
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got %0d want %0d", popped, NCYC);
    $fatal(1, "time limit");
  end

endmodule
